// File: rtl/decoder_round.sv
// Grasshopper (Kuznyechik) inverse round: data_o = S^-1(L^-1(data_i ^ key_i)).
// L^-1 is iterated R_PER_CYCLE steps per clock, then one cycle of inverse S-box.
module decoder_round #(
    parameter int R_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    if (R_PER_CYCLE != 1 && R_PER_CYCLE != 2 && R_PER_CYCLE != 4 &&
        R_PER_CYCLE != 8 && R_PER_CYCLE != 16) begin : g_bad_r_per_cycle
        $error("decoder_round: R_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, LIN, SUB, DONE} state_t;

    localparam logic [4:0] RSTEP = 5'(R_PER_CYCLE);

    // coefficient of x_k in l(x15..x0), indexed by k
    localparam logic [7:0] LC [16] = '{
        8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
        8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
    };

    // forward pi table; the inverse S-box is derived from it by lookup
    localparam logic [7:0] PI [256] = '{
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    // GF(2^8) multiply modulo x^8+x^7+x^6+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] m;
        p = '0;
        m = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    // new low byte is l(a14..a0, a15): x_k = a_(k-1) for k>=1, x0 = a15
    function automatic logic [127:0] rinv_step(input logic [127:0] a);
        logic [7:0] acc;
        acc = a[127:120];
        for (int k = 1; k < 16; k++) acc ^= gf_mul(a[(k-1)*8 +: 8], LC[k]);
        return {a[119:0], acc};
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) if (PI[i] == b) r = 8'(i);
        return r;
    endfunction

    state_t       state_q;
    logic [4:0]   cnt_q;
    logic [127:0] work_q;
    logic [127:0] data_q;
    logic [127:0] lin_d;
    logic [127:0] sub_d;
    logic [127:0] step [R_PER_CYCLE+1];

    assign step[0] = work_q;
    for (genvar g = 0; g < R_PER_CYCLE; g++) begin : g_step
        assign step[g+1] = rinv_step(step[g]);
    end
    assign lin_d = step[R_PER_CYCLE];

    always_comb begin
        sub_d = '0;
        for (int j = 0; j < 16; j++) sub_d[j*8 +: 8] = sbox_inv(work_q[j*8 +: 8]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    work_q  <= data_i ^ key_i;
                    cnt_q   <= '0;
                    state_q <= LIN;
                end
                LIN: begin
                    work_q <= lin_d;
                    cnt_q  <= cnt_q + RSTEP;
                    if (cnt_q + RSTEP == 5'd16) state_q <= SUB;
                end
                SUB: begin
                    data_q  <= sub_d;
                    state_q <= DONE;
                end
                DONE: if (ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign data_o  = data_q;

endmodule

// File: doc/decoder_round.md
# decoder_round

Sequential inverse-round core for Grasshopper (GOST R 34.12-2015, Kuznyechik) decryption; the decode-side counterpart of the forward substitution layer. It accepts one 128-bit block plus round key, computes S⁻¹(L⁻¹(data ⊕ key)) iteratively, and returns the result over a valid/ready handshake. It sits in the decryption datapath and is driven once per round by the round controller.

## Interface
- `R_PER_CYCLE`, default 1: number of R⁻¹ steps applied per clock. Legal values are 1, 2, 4, 8 and 16. Any other value is a elaboration error.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `valid_i`  input  1  input block and key are valid.
- `ready_o`  output  1  core is idle and can accept a block.
- `data_i`  input  128  ciphertext-side block. Byte a15 is `[127:120]`; byte a0 is `[7:0]`.
- `key_i`  input  128  round key, using the same byte order.
- `valid_o`  output  1  `data_o` holds a finished result.
- `ready_i`  input  1  the consumer accepts the result.
- `data_o`  output  128  result S⁻¹(L⁻¹(data_i ⊕ key_i)).

## Operation
- **FSM states:** IDLE, LIN, SUB, DONE.
  - `ready_o` = (state == IDLE).
  - `valid_o` = (state == DONE).
- **IDLE:**
  - On `valid_i & ready_o`: `work` ← `data_i ^ key_i`, `cnt` ← 0, go to LIN.
  - `data_i` and `key_i` are sampled only on this accept edge.
- **LIN:**
  - Each cycle, apply R⁻¹ `R_PER_CYCLE` times to `work`.
  - `cnt` += `R_PER_CYCLE`.
  - When `cnt + R_PER_CYCLE == 16`, go to SUB.
- **R⁻¹ step:** for `a = a15..a0`, the result is `{a[119:0], l(a14, a13, …, a0, a15)}`.
- **l function:** l(x15..x0) = 148·x15 ⊕ 32·x14 ⊕ 133·x13 ⊕ 16·x12 ⊕ 194·x11 ⊕ 192·x10 ⊕ 1·x9 ⊕ 251·x8 ⊕ 1·x7 ⊕ 192·x6 ⊕ 194·x5 ⊕ 16·x4 ⊕ 133·x3 ⊕ 32·x2 ⊕ 148·x1 ⊕ 1·x0.
  - Multiplication is in GF(2⁸) modulo x⁸+x⁷+x⁶+x+1 (0x1C3).
  - ⊕ is XOR.
  - All intermediates are 8 bits.
- **SUB:**
  - `data_o` ← inverse S-box applied to each of the 16 bytes of `work`.
  - Go to DONE.
  - The inverse S-box is the exact inverse of the standard π table. Examples: π⁻¹(0x00)=0xA5, π⁻¹(0xFC)=0x00, π⁻¹(0x64)=0xAC, π⁻¹(0x94)=0x95.
- **DONE:**
  - Hold `data_o` stable.
  - On `valid_o & ready_i`, go to IDLE.
- **Ignored inputs:**
  - `valid_i` in LIN, SUB and DONE is ignored; no accept occurs.
  - `ready_i` outside DONE is ignored.
- `data_o` changes only on the SUB→DONE edge. It keeps the last result after the handshake, until the next SUB.

## Timing
- **Reset values** (asynchronous, while `rst`=0):
  - state = IDLE, `cnt` = 0, `work` = 0.
  - `data_o` = 0, `valid_o` = 0, `ready_o` = 1.
- **Latency:** accept edge at T → `valid_o` rises after edge T + 16/`R_PER_CYCLE` + 1.
  - `R_PER_CYCLE`=1: `valid_o` rises after edge T+17.
  - `R_PER_CYCLE`=16: `valid_o` rises after edge T+2.
- **Output handshake:**
  - `valid_o` stays high until the edge where `ready_i`=1.
  - If `ready_i` is already high when DONE is entered, the handshake completes on the next edge. DONE then lasts exactly one cycle.
- **Back-to-back blocks:**
  - `ready_o` rises the cycle after the output handshake.
  - Minimum spacing between accepts is 16/`R_PER_CYCLE` + 3 cycles.
  - There is no accept in the cycle of the output handshake.
- **Reset mid-operation:**
  - Reset in LIN, SUB or DONE aborts immediately.
  - The partial result is discarded and outputs return to their reset values.
  - The first accept after reset release is processed normally.
- **Input handshake:** `valid_i` held high with `ready_o` low does not stall the FSM and creates no pending request.

## Test plan
- **L⁻¹ and S⁻¹ vector:** `key_i`=0, `data_i`=d456584dd0e3e84cc3166e4b7fa2890d → `data_o`=acba95a5a5a5a5a5a5a5a5a5a5a5a5a5.
  - With `R_PER_CYCLE`=1, `valid_o` rises exactly 17 edges after accept.
- **Key cancellation:** `data_i`=`key_i`=0123456789abcdeffedcba9876543210 → `data_o`=a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5.
- **Single R⁻¹ check:** build with `R_PER_CYCLE`=16; `data_i`=94000000000000000000000000000001, `key_i`=0.
  - Peek at `work` after the first LIN edge: the R⁻¹ result 00000000000000000000000000000100 must appear among the steps.
  - `data_o` must equal `R_PER_CYCLE`=1 runs of the same input.
- **Output backpressure:** hold `ready_i`=0 for 10 cycles after `valid_o` rises.
  - `data_o` and `valid_o` stay stable and `ready_o` stays 0.
  - Raise `ready_i`: `valid_o` falls on the next edge, and `ready_o`=1 the cycle after.
- **Busy and reset:**
  - Pulse `valid_i` with a new block during LIN: no effect on the result.
  - Assert `rst`=0 asynchronously mid-LIN: immediately `valid_o`=0, `ready_o`=1, `data_o`=0.
  - After release, vector 1 runs correctly.
- **Parameter sweep:** run vector 1 with `R_PER_CYCLE` ∈ {1,2,4,8,16}.
  - Results are identical.
  - Latency from accept to `valid_o` is 17, 9, 5, 3 and 2 edges respectively.
